// File: rtl/sata_fis_crc_appender.sv
// rtl/sata_fis_crc_appender.sv - passes FIS dwords through and appends a SATA CRC32 dword per packet
//
// Ports:
//   clk, reset       clock; asynchronous active-high reset
//   i_dat/i_val/i_eop/i_rdy   upstream dword stream (eop marks last dword)
//   o_dat/o_val/o_eop/o_crc/o_rdy  downstream stream; o_eop/o_crc flag the appended CRC dword
//   err_long         one-cycle pulse when a packet grows past MAXLEN dwords

module sata_fis_crc_appender #(
  parameter logic [31:0] CRC_INIT = 32'h52325032,
  parameter int          MAXLEN   = 2049
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_dat,
  input  logic        i_val,
  input  logic        i_eop,
  output logic        i_rdy,
  output logic [31:0] o_dat,
  output logic        o_val,
  output logic        o_eop,
  output logic        o_crc,
  input  logic        o_rdy,
  output logic        err_long
);

  localparam int          LW      = $clog2(MAXLEN + 2);
  localparam logic [31:0] POLY    = 32'h04C11DB7;
  localparam logic [LW-1:0] LEN_MAX = LW'(MAXLEN);
  localparam logic [LW-1:0] LEN_SAT = LW'(MAXLEN + 1);

  typedef enum logic {S_DATA, S_CRC} state_t;

  state_t         state, state_nx;
  logic [31:0]    crc_reg;
  logic [LW-1:0]  len_cnt;
  logic           err_done;
  logic           accept;

  // Full-dword CRC step, data bit 31 enters first; unrolled into a parallel XOR network.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [31:0] d);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 31; i >= 0; i--) begin
      fb = r[31] ^ d[i];
      r  = {r[30:0], 1'b0} ^ ({32{fb}} & POLY);
    end
    return r;
  endfunction

  assign accept = (state == S_DATA) && i_val && o_rdy;

  always_comb begin
    state_nx = state;
    o_dat    = i_dat;
    o_val    = i_val;
    o_eop    = 1'b0;
    o_crc    = 1'b0;
    i_rdy    = o_rdy;
    case (state)
      S_DATA: begin
        if (accept && i_eop) state_nx = S_CRC;
      end
      S_CRC: begin
        o_dat = crc_reg;
        o_val = 1'b1;
        o_eop = 1'b1;
        o_crc = 1'b1;
        i_rdy = 1'b0;
        if (o_rdy) state_nx = S_DATA;
      end
      default: state_nx = S_DATA;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_DATA;
      crc_reg  <= CRC_INIT;
      len_cnt  <= '0;
      err_done <= 1'b0;
      err_long <= 1'b0;
    end else begin
      state    <= state_nx;
      err_long <= 1'b0;
      if (accept) begin
        crc_reg <= crc_step(crc_reg, i_dat);
        if (len_cnt != LEN_SAT) len_cnt <= len_cnt + 1'b1;
        // Crossing from MAXLEN to MAXLEN+1 is the only trigger; err_done keeps it to once per packet.
        if (len_cnt == LEN_MAX && !err_done) begin
          err_long <= 1'b1;
          err_done <= 1'b1;
        end
      end else if (state == S_CRC && o_rdy) begin
        crc_reg  <= CRC_INIT;
        len_cnt  <= '0;
        err_done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sata_fis_crc_appender.sv
// tb/tb_sata_fis_crc_appender.sv - randomized scoreboard bench for sata_fis_crc_appender

module tb_sata_fis_crc_appender;

  localparam logic [31:0] CRC_INIT = 32'h52325032;
  localparam int          MAXLEN   = 2049;
  localparam logic [31:0] POLY     = 32'h04C11DB7;

  logic        clk;
  logic        reset;
  logic [31:0] i_dat;
  logic        i_val;
  logic        i_eop;
  logic        i_rdy;
  logic [31:0] o_dat;
  logic        o_val;
  logic        o_eop;
  logic        o_crc;
  logic        o_rdy;
  logic        err_long;

  sata_fis_crc_appender #(.CRC_INIT(CRC_INIT), .MAXLEN(MAXLEN)) dut (
    .clk(clk), .reset(reset),
    .i_dat(i_dat), .i_val(i_val), .i_eop(i_eop), .i_rdy(i_rdy),
    .o_dat(o_dat), .o_val(o_val), .o_eop(o_eop), .o_crc(o_crc), .o_rdy(o_rdy),
    .err_long(err_long)
  );

  typedef struct {
    logic [31:0] dat;
    logic        eop;
    logic        crc;
    int          errs;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] pkt[$];
  int          checks = 0;
  int          failures = 0;
  int          rdy_mode = 0;   // 0: ready high, 1: random, 2: ready low
  bit          hold_chk_en = 1;
  bit          mark_en = 0;
  int          mark_first = -1;
  int          mark_last = 0;
  int          mark_n = 0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference CRC: classic word-at-a-time long division over the packet dwords.
  function automatic logic [31:0] model_crc();
    logic [31:0] c;
    c = CRC_INIT;
    foreach (pkt[k]) begin
      c = c ^ pkt[k];
      repeat (32) c = c[31] ? ((c << 1) ^ POLY) : (c << 1);
    end
    return c;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    o_rdy = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       o_rdy = 1'b1;
        1:       o_rdy = 1'($urandom_range(0, 1));
        default: o_rdy = 1'b0;
      endcase
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor / scoreboard
  initial begin
    int          cyc = 0;
    int          pkt_acc = 0;
    int          pkt_err = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_dat = '0;
    logic        prev_eop = 0;
    logic        prev_crc = 0;
    beat_t       e;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        chk(!o_val && !o_eop && !o_crc, "reset_outputs_idle", {o_val, o_eop, o_crc}, 0);
        chk(!err_long, "reset_err_long", err_long, 0);
        pkt_acc = 0;
        pkt_err = 0;
        prev_stall = 0;
      end else begin
        if (err_long) begin
          pkt_err++;
          chk(pkt_acc == MAXLEN + 1, "err_long_timing", pkt_acc, MAXLEN + 1);
        end
        if (o_val && o_crc) chk(!i_rdy, "i_rdy_low_in_crc", i_rdy, 0);
        if (hold_chk_en && prev_stall)
          chk(o_val && o_dat == prev_dat && o_eop == prev_eop && o_crc == prev_crc,
              "stall_hold_stable", o_dat, prev_dat);
        if (i_val && i_rdy) pkt_acc++;
        if (o_val && o_rdy) begin
          if (mark_en) begin
            if (mark_first < 0) mark_first = cyc;
            mark_last = cyc;
            mark_n++;
          end
          if (exp_q.size() == 0) begin
            chk(0, "unexpected_beat", o_dat, 0);
          end else begin
            e = exp_q.pop_front();
            chk(o_dat == e.dat, e.crc ? "crc_dword" : "data_dword", o_dat, e.dat);
            chk(o_eop == e.eop && o_crc == e.crc, "beat_flags", {o_eop, o_crc}, {e.eop, e.crc});
            if (e.crc) begin
              chk(pkt_err == e.errs, "err_long_pulses", pkt_err, e.errs);
              pkt_acc = 0;
              pkt_err = 0;
            end
          end
        end
        prev_stall = o_val && !o_rdy;
        prev_dat   = o_dat;
        prev_eop   = o_eop;
        prev_crc   = o_crc;
      end
    end
  end

  task automatic wait_accept();
    bit done = 0;
    for (int t = 0; t < 2000 && !done; t++) begin
      @(negedge clk);
      if (i_rdy) begin
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    if (!done) chk(0, "accept_timeout", 0, 1);
  endtask

  task automatic send_packet(input int stall_at, input bit hold_crc);
    int    n;
    int    saved;
    beat_t b;
    n = pkt.size();
    foreach (pkt[k]) begin
      b.dat = pkt[k]; b.eop = 0; b.crc = 0; b.errs = 0;
      exp_q.push_back(b);
    end
    b.dat = model_crc(); b.eop = 1; b.crc = 1; b.errs = (n > MAXLEN) ? 1 : 0;
    exp_q.push_back(b);
    for (int k = 0; k < n; k++) begin
      if (k == stall_at) begin
        saved = rdy_mode;
        rdy_mode = 2;
        hold_chk_en = 0;
        repeat (20) begin
          i_val = 1'b1;
          i_dat = $urandom;
          i_eop = 1'($urandom_range(0, 1));
          @(negedge clk);
          chk(!i_rdy, "stall_no_accept", i_rdy, 0);
          @(posedge clk);
          #1;
        end
        i_dat = pkt[k];
        i_eop = (k == n - 1);
        @(posedge clk);
        #1;
        rdy_mode = saved;
        hold_chk_en = 1;
      end
      i_val = 1'b1;
      i_dat = pkt[k];
      i_eop = (k == n - 1);
      wait_accept();
    end
    i_val = 1'b0;
    i_eop = 1'b0;
    if (hold_crc) rdy_mode = 2;
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 10000 && exp_q.size() != 0; t++) @(negedge clk);
    chk(exp_q.size() == 0, "drain_timeout", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic load_test1();
    pkt.delete();
    pkt.push_back(32'h00000046);
    pkt.push_back(32'h11111111);
    pkt.push_back(32'h22222222);
    pkt.push_back(32'h33333333);
  endtask

  task automatic load_random(input int n);
    pkt.delete();
    for (int k = 0; k < n; k++) pkt.push_back($urandom);
  endtask

  initial begin
    reset = 1'b1;
    i_dat = '0;
    i_val = 1'b0;
    i_eop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // 1: fixed packet, ready always high
    rdy_mode = 0;
    load_test1();
    send_packet(-1, 0);
    wait_drain();

    // 2: same packet, random backpressure
    rdy_mode = 1;
    load_test1();
    send_packet(-1, 0);
    wait_drain();

    // 3: back-to-back 1 / 2049 / 5 with no gaps
    rdy_mode = 0;
    mark_en = 1;
    load_random(1);    send_packet(-1, 0);
    load_random(2049); send_packet(-1, 0);
    load_random(5);    send_packet(-1, 0);
    wait_drain();
    mark_en = 0;
    chk(mark_n == 2058, "b2b_beat_count", mark_n, 2058);
    chk(mark_last - mark_first + 1 == 2058, "b2b_cycle_span", mark_last - mark_first + 1, 2058);

    // 4: overlong packets
    rdy_mode = 0;
    load_random(2050); send_packet(-1, 0);
    wait_drain();
    rdy_mode = 1;
    load_random(2051); send_packet(-1, 0);
    wait_drain();

    // 5: reset while the CRC beat is stalled
    rdy_mode = 0;
    load_random(3);
    send_packet(-1, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(o_val && o_crc, "held_in_crc", {o_val, o_crc}, 2'b11);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    reset = 1'b0;
    rdy_mode = 0;
    load_test1();
    send_packet(-1, 0);
    wait_drain();

    // 6: 20-cycle backpressure mid-packet with garbage on the input
    rdy_mode = 0;
    load_random(8);
    send_packet(4, 0);
    wait_drain();

    // Randomized packets under random backpressure
    rdy_mode = 1;
    for (int p = 0; p < 12; p++) begin
      load_random($urandom_range(1, 20));
      send_packet(-1, 0);
    end
    wait_drain();

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
